// File: rtl/space_invaders_pkg.sv
// Shared types and limits for the space invaders game blocks.
// Holds the fire-FSM states, missile slot count, column width and screen limits.
package space_invaders_pkg;

    localparam int unsigned NUM_SLOTS       = 8;
    localparam int unsigned SLOT_W          = 3;
    localparam int unsigned COL_W           = 12;
    localparam int unsigned SCREEN_COL_MIN  = 0;
    localparam int unsigned SCREEN_COL_MAX  = 609;
    localparam int unsigned SCREEN_COL_INIT = 305;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RELEASE,
        COOL
    } fire_state_t;

    typedef struct packed {
        logic              found;
        logic [SLOT_W-1:0] idx;
    } slot_sel_t;

    // Lowest-index slot whose busy flag is clear.
    function automatic slot_sel_t lowest_free(input logic [NUM_SLOTS-1:0] busy);
        slot_sel_t sel;
        sel = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!busy[i] && !sel.found) begin
                sel.found = 1'b1;
                sel.idx   = SLOT_W'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for one pushbutton.
// The level flips only after the synchronized input has differed for DEBOUNCE_CYCLES clocks.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 315000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/player_ctrl.sv
// Player cannon control: debounced buttons drive a rate-limited column and a
// fire FSM that issues toggle-handshake requests to the lowest free missile slot.
module player_ctrl
    import space_invaders_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 315000,
    parameter int unsigned MOVE_DIV        = 250000,
    parameter int unsigned COOLDOWN        = 3150000,
    parameter int unsigned COL_MIN         = SCREEN_COL_MIN,
    parameter int unsigned COL_MAX         = SCREEN_COL_MAX,
    parameter int unsigned COL_INIT        = SCREEN_COL_INIT,
    parameter int unsigned STEP            = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_left,
    input  logic                 btn_right,
    input  logic                 btn_fire,
    input  logic [NUM_SLOTS-1:0] missle_busy,
    output logic [COL_W-1:0]     btn_col,
    output logic [NUM_SLOTS-1:0] btn_missle_en,
    output logic                 fire_pulse
);

    localparam int unsigned MW    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int unsigned KW    = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam int unsigned COL_XW = COL_W + 1;
    localparam logic [COL_XW-1:0] MIN_X  = COL_XW'(COL_MIN);
    localparam logic [COL_XW-1:0] MAX_X  = COL_XW'(COL_MAX);
    localparam logic [COL_XW-1:0] STEP_X = COL_XW'(STEP);

    logic left_db;
    logic right_db;
    logic fire_db;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk(clk), .rst(rst), .raw(btn_left), .level(left_db)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk(clk), .rst(rst), .raw(btn_right), .level(right_db)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fire (
        .clk(clk), .rst(rst), .raw(btn_fire), .level(fire_db)
    );

    logic [MW-1:0]     move_cnt;
    logic              tick;
    logic [COL_XW-1:0] col_x;
    logic [COL_W-1:0]  col_next;

    assign tick  = (move_cnt == MW'(MOVE_DIV - 1));
    assign col_x = {1'b0, btn_col};

    // Clamp in a widened domain so a step below COL_MIN cannot wrap.
    always_comb begin
        col_next = btn_col;
        if (tick) begin
            unique case ({left_db, right_db})
                2'b10: col_next = (col_x >= MIN_X + STEP_X) ? COL_W'(col_x - STEP_X) : COL_W'(MIN_X);
                2'b01: col_next = (col_x + STEP_X <= MAX_X) ? COL_W'(col_x + STEP_X) : COL_W'(MAX_X);
                default: col_next = btn_col;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            move_cnt <= '0;
            btn_col  <= COL_W'(COL_INIT);
        end else begin
            move_cnt <= tick ? '0 : move_cnt + 1'b1;
            btn_col  <= col_next;
        end
    end

    fire_state_t          state;
    fire_state_t          state_next;
    logic                 fire_prev;
    logic [KW-1:0]        cool_cnt;
    logic [KW-1:0]        cool_next;
    logic [NUM_SLOTS-1:0] en_next;
    logic                 pulse_next;
    slot_sel_t            sel;

    assign sel = lowest_free(missle_busy);

    always_comb begin
        state_next = state;
        en_next    = btn_missle_en;
        pulse_next = 1'b0;
        cool_next  = '0;
        unique case (state)
            IDLE: begin
                if (fire_db && !fire_prev) state_next = ISSUE;
            end
            ISSUE: begin
                if (sel.found) begin
                    en_next[sel.idx] = ~btn_missle_en[sel.idx];
                    pulse_next       = 1'b1;
                end
                state_next = RELEASE;
            end
            RELEASE: begin
                if (!fire_db) state_next = COOL;
            end
            COOL: begin
                if (cool_cnt == KW'(COOLDOWN - 1)) state_next = IDLE;
                else cool_next = cool_cnt + 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            fire_prev     <= 1'b0;
            cool_cnt      <= '0;
            btn_missle_en <= '0;
            fire_pulse    <= 1'b0;
        end else begin
            state         <= state_next;
            fire_prev     <= fire_db;
            cool_cnt      <= cool_next;
            btn_missle_en <= en_next;
            fire_pulse    <= pulse_next;
        end
    end

endmodule

// File: tb/tb_player_ctrl.sv
// Self-checking bench for player_ctrl: shot scoreboard plus column step/range monitors.
// Three instances share stimulus: nominal, one starting near COL_MAX, one pinned at COL_MIN.
module tb_player_ctrl;
    import space_invaders_pkg::*;

    logic       clk;
    logic       rst;
    logic       btn_left;
    logic       btn_right;
    logic       btn_fire;
    logic       zero_bit;
    logic [7:0] missle_busy;

    logic [11:0] col, col_hi, col_lo;
    logic [7:0]  en, en_hi, en_lo;
    logic        pulse, pulse_hi, pulse_lo;

    int assertions = 0;
    int failures   = 0;
    int pulse_cnt  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_en = '0;

    player_ctrl #(.DEBOUNCE_CYCLES(4), .MOVE_DIV(8), .COOLDOWN(16), .STEP(2)) dut (
        .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(btn_right), .btn_fire(btn_fire),
        .missle_busy(missle_busy), .btn_col(col), .btn_missle_en(en), .fire_pulse(pulse)
    );

    player_ctrl #(.DEBOUNCE_CYCLES(4), .MOVE_DIV(8), .COOLDOWN(16), .STEP(2), .COL_INIT(601)) dut_hi (
        .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(btn_right), .btn_fire(btn_fire),
        .missle_busy(missle_busy), .btn_col(col_hi), .btn_missle_en(en_hi), .fire_pulse(pulse_hi)
    );

    player_ctrl #(.DEBOUNCE_CYCLES(4), .MOVE_DIV(8), .COOLDOWN(16), .STEP(2), .COL_INIT(0)) dut_lo (
        .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(zero_bit), .btn_fire(btn_fire),
        .missle_busy(missle_busy), .btn_col(col_lo), .btn_missle_en(en_lo), .fire_pulse(pulse_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shot scoreboard: each pulse pops the btn_missle_en value expected after that shot.
    initial begin : pulse_monitor
        logic       prev_pulse;
        logic [7:0] want;
        prev_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && pulse === 1'b1) begin
                pulse_cnt++;
                assertions++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse: en=%02h with no shot expected", en);
                end else begin
                    want = exp_q.pop_front();
                    if (en !== want) begin
                        failures++;
                        $display("FAIL shot_en: got %02h expected %02h", en, want);
                    end
                end
                assertions++;
                if (prev_pulse === 1'b1) begin
                    failures++;
                    $display("FAIL pulse_width: got 2+ cycles expected 1");
                end
            end
            prev_pulse = (rst === 1'b1) ? pulse : 1'b0;
        end
    end

    // Column monitor: range on every instance, and nominal moves are +-STEP on tick boundaries.
    initial begin : col_monitor
        logic [11:0] prev_col;
        int          since;
        bit          have_change;
        prev_col    = 12'd305;
        since       = 0;
        have_change = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                prev_col    = 12'd305;
                since       = 0;
                have_change = 1'b0;
            end else begin
                since++;
                assertions++;
                if (col > 12'd609 || col_hi > 12'd609 || col_lo > 12'd609) begin
                    failures++;
                    $display("FAIL col_range: got %0d/%0d/%0d expected <= 609", col, col_hi, col_lo);
                end
                if (col !== prev_col) begin
                    assertions++;
                    if (!(col == prev_col + 12'd2 || col + 12'd2 == prev_col)) begin
                        failures++;
                        $display("FAIL col_step: got %0d->%0d expected step of 2", prev_col, col);
                    end
                    if (have_change) begin
                        assertions++;
                        if (since % 8 != 0) begin
                            failures++;
                            $display("FAIL col_tick: got %0d cycles between moves expected multiple of 8", since);
                        end
                    end
                    have_change = 1'b1;
                    since       = 0;
                    prev_col    = col;
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_fire = 1'b0; zero_bit = 1'b0;
        missle_busy = 8'h00;
        repeat (3) @(negedge clk);
        assertions++;
        if (col !== 12'd305 || en !== 8'h00 || pulse !== 1'b0 || dut.state !== IDLE) begin
            failures++;
            $display("FAIL reset_state: got col=%0d en=%02h pulse=%b expected 305/00/0 IDLE", col, en, pulse);
        end
        rst = 1'b1;
        repeat (100) @(negedge clk);
        assertions++;
        if (col !== 12'd305 || en !== 8'h00 || pulse_cnt !== 0) begin
            failures++;
            $display("FAIL idle_100: got col=%0d en=%02h pulses=%0d expected 305/00/0", col, en, pulse_cnt);
        end
    endtask

    task automatic test_move();
        bit moved;
        btn_right = 1'b1;
        repeat (80) @(negedge clk);
        // Debounce takes 6 edges, leaving 9 or 10 ticks of the free-running divider.
        assertions++;
        if (col < 12'd323 || col > 12'd325) begin
            failures++;
            $display("FAIL right_80: got %0d expected 323..325", col);
        end
        assertions++;
        if (col_hi !== 12'd609) begin
            failures++;
            $display("FAIL right_clamp: got %0d expected 609", col_hi);
        end
        btn_right = 1'b0;
        btn_left  = 1'b1;
        moved = 1'b0;
        for (int i = 0; i < 40 && !moved; i++) begin
            @(negedge clk);
            if (col_hi !== 12'd609) moved = 1'b1;
        end
        btn_left = 1'b0;
        assertions++;
        if (!moved || col_hi !== 12'd607) begin
            failures++;
            $display("FAIL left_from_max: got %0d expected 607 within 40 clocks", col_hi);
        end
        repeat (10) @(negedge clk);
        btn_left = 1'b1;
        repeat (40) @(negedge clk);
        btn_left = 1'b0;
        assertions++;
        if (col_lo !== 12'd0) begin
            failures++;
            $display("FAIL left_clamp_min: got %0d expected 0", col_lo);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_bounce();
        int base;
        base = pulse_cnt;
        missle_busy = 8'h00;
        btn_fire = 1'b1; @(negedge clk);
        btn_fire = 1'b0; @(negedge clk);
        btn_fire = 1'b1; @(negedge clk);
        btn_fire = 1'b0;
        repeat (12) @(negedge clk);
        assertions++;
        if (pulse_cnt !== base) begin
            failures++;
            $display("FAIL bounce_only: got %0d pulses expected 0", pulse_cnt - base);
        end
        exp_en ^= 8'h01;
        exp_q.push_back(exp_en);
        btn_fire = 1'b1;
        repeat (10) @(negedge clk);
        btn_fire = 1'b0;
        repeat (30) @(negedge clk);
        assertions++;
        if (pulse_cnt !== base + 1 || en !== 8'h01 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL clean_press: got pulses=%0d en=%02h expected 1/01", pulse_cnt - base, en);
        end
    endtask

    task automatic test_busy_slots();
        int base;
        bit seen_rel, seen_cool;
        missle_busy = 8'h07;
        exp_en ^= 8'h08;
        exp_q.push_back(exp_en);
        btn_fire = 1'b1;
        repeat (10) @(negedge clk);
        btn_fire = 1'b0;
        repeat (30) @(negedge clk);
        assertions++;
        if (en !== 8'h09 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL busy_07: got en=%02h expected 09", en);
        end
        base = pulse_cnt;
        missle_busy = 8'hFF;
        seen_rel = 1'b0; seen_cool = 1'b0;
        btn_fire = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 10) btn_fire = 1'b0;
            if (dut.state === RELEASE) seen_rel = 1'b1;
            if (dut.state === COOL && seen_rel) seen_cool = 1'b1;
        end
        assertions++;
        if (pulse_cnt !== base || en !== 8'h09) begin
            failures++;
            $display("FAIL all_busy: got pulses=%0d en=%02h expected 0/09", pulse_cnt - base, en);
        end
        assertions++;
        if (!seen_rel || !seen_cool || dut.state !== IDLE) begin
            failures++;
            $display("FAIL all_busy_fsm: got rel=%b cool=%b expected 1/1 then IDLE", seen_rel, seen_cool);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = pulse_cnt;
        missle_busy = 8'h00;
        exp_en ^= 8'h01;
        exp_q.push_back(exp_en);
        btn_fire = 1'b1;
        repeat (200) @(negedge clk);
        btn_fire = 1'b0;
        repeat (5) @(negedge clk);
        btn_fire = 1'b1;
        repeat (6) @(negedge clk);
        btn_fire = 1'b0;
        repeat (9) @(negedge clk);
        assertions++;
        if (pulse_cnt !== base + 1 || en !== 8'h08) begin
            failures++;
            $display("FAIL hold_and_early: got pulses=%0d en=%02h expected 1/08", pulse_cnt - base, en);
        end
        missle_busy = 8'h01;
        exp_en ^= 8'h02;
        exp_q.push_back(exp_en);
        btn_fire = 1'b1;
        repeat (10) @(negedge clk);
        btn_fire = 1'b0;
        repeat (30) @(negedge clk);
        assertions++;
        if (pulse_cnt !== base + 2 || en !== 8'h0A || exp_q.size() != 0) begin
            failures++;
            $display("FAIL late_press: got pulses=%0d en=%02h expected 2/0A", pulse_cnt - base, en);
        end
    endtask

    task automatic test_reset_abort();
        int base;
        missle_busy = 8'h00;
        exp_en ^= 8'h01;
        exp_q.push_back(exp_en);
        btn_fire = 1'b1;
        repeat (10) @(negedge clk);
        btn_fire = 1'b0;
        repeat (12) @(negedge clk);
        assertions++;
        if (dut.state !== COOL || en !== 8'h0B) begin
            failures++;
            $display("FAIL pre_abort_cool: got en=%02h expected 0B in COOL", en);
        end
        #2 rst = 1'b0;
        #1;
        assertions++;
        if (col !== 12'd305 || en !== 8'h00 || pulse !== 1'b0 || dut.state !== IDLE) begin
            failures++;
            $display("FAIL abort_cool: got col=%0d en=%02h pulse=%b expected 305/00/0", col, en, pulse);
        end
        exp_en = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_en ^= 8'h01;
        exp_q.push_back(exp_en);
        btn_fire = 1'b1;
        repeat (20) @(negedge clk);
        assertions++;
        if (dut.state !== RELEASE || en !== 8'h01) begin
            failures++;
            $display("FAIL pre_abort_release: got en=%02h expected 01 in RELEASE", en);
        end
        btn_fire = 1'b0;
        #2 rst = 1'b0;
        #1;
        assertions++;
        if (col !== 12'd305 || en !== 8'h00 || pulse !== 1'b0 || dut.state !== IDLE) begin
            failures++;
            $display("FAIL abort_release: got col=%0d en=%02h pulse=%b expected 305/00/0", col, en, pulse);
        end
        exp_en = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        base = pulse_cnt;
        repeat (20) @(negedge clk);
        assertions++;
        if (pulse_cnt !== base || en !== 8'h00 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL post_abort_quiet: got pulses=%0d en=%02h expected 0/00", pulse_cnt - base, en);
        end
        exp_en ^= 8'h01;
        exp_q.push_back(exp_en);
        btn_fire = 1'b1;
        repeat (10) @(negedge clk);
        btn_fire = 1'b0;
        repeat (30) @(negedge clk);
        assertions++;
        if (pulse_cnt !== base + 1 || en !== 8'h01 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL post_abort_fire: got pulses=%0d en=%02h expected 1/01", pulse_cnt - base, en);
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_bounce();
        test_busy_slots();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
